seq_signed_divider: RTL

SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

---
 rtl/seq_div_pkg.sv | 17 +
 rtl/div_step.sv | 33 +++
 rtl/seq_signed_divider.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// ----------------------------------------------------------------------------
// seq_div_pkg
// Shared definitions for the sequential signed divider:
//   DEFAULT_WIDTH - default operand/result width
//   div_state_t   - controller states (IDLE, CALC, SIGN)
// ----------------------------------------------------------------------------
package seq_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One radix-2 restoring division step (purely combinational).
//   i_rem      - current partial remainder (WIDTH+1 bits)
//   i_dvd_msb  - next dividend bit shifted into the partial remainder
//   i_dvs_mag  - divisor magnitude
//   o_rem      - next partial remainder (restored if trial subtract < 0)
//   o_qbit     - quotient bit produced by this step
// ----------------------------------------------------------------------------
module div_step
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_dvd_msb,
    input  logic [WIDTH-1:0] i_dvs_mag,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;

    // One extra bit above the shifted remainder acts as the borrow/sign bit
    // of the trial subtraction.
    assign w_shift = {i_rem, i_dvd_msb};
    assign w_diff  = w_shift - {2'b00, i_dvs_mag};

    assign o_qbit = ~w_diff[WIDTH+1];
    assign o_rem  = o_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/seq_signed_divider.sv
// ----------------------------------------------------------------------------
// seq_signed_divider
// Sequential signed divider: restoring division on operand magnitudes, one
// quotient bit per clock, followed by a sign-fixup cycle.
//   clk        - clock, rising edge
//   resetN     - asynchronous active-low reset
//   Dividend   - signed numerator, sampled on accepted start
//   Divisor    - signed denominator, sampled on accepted start
//   start      - request pulse, accepted only when busy=0
//   Quotient   - signed quotient, truncated toward zero (registered)
//   Remainder  - signed remainder with the sign of Dividend (registered)
//   busy       - operation in progress
//   done       - one-cycle pulse when Quotient/Remainder update
//   divByZero  - set with done when the divisor was zero, held until next done
// ----------------------------------------------------------------------------
module seq_signed_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    input  logic             start,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             divByZero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;     // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0] r_dvs;     // divisor magnitude
    logic [WIDTH:0]   r_rem;     // partial remainder
    logic             r_qsign;
    logic             r_rsign;
    logic             r_dbz;

    logic [WIDTH:0]   w_dvd_ext;
    logic [WIDTH:0]   w_dvs_ext;
    logic [WIDTH:0]   w_dvd_abs;
    logic [WIDTH:0]   w_dvs_abs;
    logic [WIDTH:0]   w_q_ext;
    logic [WIDTH:0]   w_q_res;
    logic [WIDTH:0]   w_r_src;
    logic [WIDTH:0]   w_r_res;
    logic [WIDTH:0]   w_step_rem;
    logic             w_step_qbit;
    logic             w_unused_bits;

    // Magnitudes are formed in WIDTH+1 bits so |-2^(WIDTH-1)| is exact; the
    // result always fits back into WIDTH unsigned bits.
    assign w_dvd_ext = {Dividend[WIDTH-1], Dividend};
    assign w_dvs_ext = {Divisor[WIDTH-1], Divisor};
    assign w_dvd_abs = Dividend[WIDTH-1] ? (~w_dvd_ext + (WIDTH+1)'(1)) : w_dvd_ext;
    assign w_dvs_abs = Divisor[WIDTH-1]  ? (~w_dvs_ext + (WIDTH+1)'(1)) : w_dvs_ext;

    assign w_q_ext = {1'b0, r_dvd};
    assign w_q_res = r_qsign ? (~w_q_ext + (WIDTH+1)'(1)) : w_q_ext;

    // On divide-by-zero the remainder is the original dividend, rebuilt from
    // its latched magnitude and sign.
    assign w_r_src = r_dbz ? {1'b0, r_dvd} : r_rem;
    assign w_r_res = r_rsign ? (~w_r_src + (WIDTH+1)'(1)) : w_r_src;

    assign w_unused_bits = ^{w_dvd_abs[WIDTH], w_dvs_abs[WIDTH], w_q_res[WIDTH], w_r_res[WIDTH]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_dvd_msb (r_dvd[WIDTH-1]),
        .i_dvs_mag (r_dvs),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_qsign   <= 1'b0;
            r_rsign   <= 1'b0;
            r_dbz     <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            divByZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvd   <= w_dvd_abs[WIDTH-1:0];
                        r_dvs   <= w_dvs_abs[WIDTH-1:0];
                        r_qsign <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                        r_rsign <= Dividend[WIDTH-1];
                        r_dbz   <= (Divisor == '0);
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (r_dbz) begin
                        Quotient  <= '1;
                        Remainder <= w_r_res[WIDTH-1:0];
                        divByZero <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        // Quotient bits shift in behind the consumed dividend bits.
                        r_rem <= w_step_rem;
                        r_dvd <= {r_dvd[WIDTH-2:0], w_step_qbit};
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST_STEP) begin
                            r_state <= SIGN;
                        end
                    end
                end
                SIGN: begin
                    Quotient  <= w_q_res[WIDTH-1:0];
                    Remainder <= w_r_res[WIDTH-1:0];
                    divByZero <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
